gcd_result_display: RTL and testbench

- Downstream consumer of the GCD calculator.
- Captures the 8-bit gcd_result when gcd_ready rises and converts it to three BCD digits with a sequential double-dabble engine.
- Drives a 4-digit multiplexed, active-low seven-segment display with leading-zero suppression.
- Also exports the packed BCD value for other consumers.

---
 rtl/gcd_result_display.sv | 190 +++++++++++++++++++
 tb/tb_gcd_result_display.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/gcd_result_display.sv
`default_nettype none
// ============================================================================
//  Module      : gcd_result_display
//  Description : Captures the 8-bit GCD result on a rising gcd_ready and
//                converts it to three BCD digits using a sequential
//                double-dabble engine (one shift per cycle, 8 cycles).
//                The BCD value is exported and drives a 4-digit multiplexed
//                active-low seven-segment display with leading-zero
//                suppression. Dashes are shown until a conversion completes.
//  Ports       :
//    clock       in   system clock, rising edge
//    reset       in   asynchronous active-high reset
//    gcd_ready   in   result-valid strobe (pulse or level)
//    gcd_result  in   [7:0]  unsigned GCD result
//    busy        out  conversion in progress
//    bcd_valid   out  bcd_value holds a completed conversion
//    bcd_value   out  [11:0] {hundreds, tens, ones}
//    anode       out  [3:0]  digit enables, active-low, bit 0 = ones
//    segments    out  [6:0]  {g,f,e,d,c,b,a}, active-low
//    dp          out  decimal point, active-low, always off
//  Revision    : 1.0  initial release
// ============================================================================
module gcd_result_display #(
    parameter int REFRESH_BITS = 18
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        gcd_ready,
    input  logic [7:0]  gcd_result,
    output logic        busy,
    output logic        bcd_valid,
    output logic [11:0] bcd_value,
    output logic [3:0]  anode,
    output logic [6:0]  segments,
    output logic        dp
);

    localparam logic [0:0] c_idle    = 1'b0;
    localparam logic [0:0] c_convert = 1'b1;

    localparam logic [6:0] c_seg_blank = 7'b1111111;
    localparam logic [6:0] c_seg_dash  = 7'b0111111;

    logic [0:0]              r_state;
    logic [0:0]              w_next_state;
    logic                    r_ready_q;
    logic [REFRESH_BITS-1:0] r_refresh;
    logic [19:0]             r_shift;
    logic [2:0]              r_iter;
    logic                    w_rise;
    logic                    w_last;
    logic [19:0]             w_adj;

    assign w_rise = gcd_ready & ~r_ready_q;
    assign w_last = (r_iter == 3'd7);

    // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift
    // so that it carries correctly into the next decade.
    always_comb begin
        w_adj = r_shift;
        if (r_shift[11:8]  >= 4'd5) w_adj[11:8]  = r_shift[11:8]  + 4'd3;
        if (r_shift[15:12] >= 4'd5) w_adj[15:12] = r_shift[15:12] + 4'd3;
        if (r_shift[19:16] >= 4'd5) w_adj[19:16] = r_shift[19:16] + 4'd3;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:    if (w_rise) w_next_state = c_convert;
            c_convert: if (w_last) w_next_state = c_idle;
            default:   w_next_state = c_idle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (r_state == c_convert);
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ready_q <= 1'b0;
            r_refresh <= '0;
            r_shift   <= '0;
            r_iter    <= '0;
            bcd_valid <= 1'b0;
            bcd_value <= '0;
        end else begin
            r_ready_q <= gcd_ready;
            r_refresh <= r_refresh + 1'b1;
            case (r_state)
                c_idle: begin
                    if (w_rise) begin
                        r_shift   <= {12'b0, gcd_result};
                        r_iter    <= '0;
                        bcd_valid <= 1'b0;
                    end
                end
                c_convert: begin
                    r_shift <= {w_adj[18:0], 1'b0};
                    r_iter  <= r_iter + 3'd1;
                    if (w_last) begin
                        // Post-shift BCD field [19:8] equals w_adj[18:7].
                        bcd_value <= w_adj[18:7];
                        bcd_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- Display ----------------
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_encode = 7'b1000000;
            4'd1:    seg_encode = 7'b1111001;
            4'd2:    seg_encode = 7'b0100100;
            4'd3:    seg_encode = 7'b0110000;
            4'd4:    seg_encode = 7'b0011001;
            4'd5:    seg_encode = 7'b0010010;
            4'd6:    seg_encode = 7'b0000010;
            4'd7:    seg_encode = 7'b1111000;
            4'd8:    seg_encode = 7'b0000000;
            4'd9:    seg_encode = 7'b0010000;
            default: seg_encode = 7'b1111111;
        endcase
    endfunction

    logic [1:0] w_idx;
    logic [3:0] w_hund;
    logic [3:0] w_tens;
    logic [3:0] w_ones;
    logic       w_show;
    logic [6:0] w_seg;

    assign w_idx  = r_refresh[REFRESH_BITS-1 -: 2];
    assign w_hund = bcd_value[11:8];
    assign w_tens = bcd_value[7:4];
    assign w_ones = bcd_value[3:0];
    assign dp     = 1'b1;

    always_comb begin
        w_show = 1'b0;
        w_seg  = c_seg_blank;
        if (w_idx == 2'd3) begin
            w_show = 1'b0;
        end else if (!bcd_valid) begin
            w_show = 1'b1;
            w_seg  = c_seg_dash;
        end else begin
            case (w_idx)
                2'd0: begin
                    w_show = 1'b1;
                    w_seg  = seg_encode(w_ones);
                end
                2'd1: begin
                    // Tens is suppressed only when it is a leading zero.
                    w_show = (w_hund != 4'd0) || (w_tens != 4'd0);
                    w_seg  = seg_encode(w_tens);
                end
                2'd2: begin
                    w_show = (w_hund != 4'd0);
                    w_seg  = seg_encode(w_hund);
                end
                default: w_show = 1'b0;
            endcase
        end
        if (w_show) begin
            anode    = ~(4'b0001 << w_idx);
            segments = w_seg;
        end else begin
            anode    = 4'b1111;
            segments = c_seg_blank;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gcd_result_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gcd_result_display
//  Description : Self-checking bench for gcd_result_display (REFRESH_BITS=4).
//                Table of conversions with expected BCD and per-digit
//                segment patterns, plus hand-written multi-cycle sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gcd_result_display;

    logic        clock;
    logic        reset;
    logic        gcd_ready;
    logic [7:0]  gcd_result;
    logic        busy;
    logic        bcd_valid;
    logic [11:0] bcd_value;
    logic [3:0]  anode;
    logic [6:0]  segments;
    logic        dp;

    int total;
    int bad;

    // Bench copy of the refresh counter (resets and counts like the DUT's).
    logic [3:0] tb_cnt;

    gcd_result_display #(.REFRESH_BITS(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .gcd_ready  (gcd_ready),
        .gcd_result (gcd_result),
        .busy       (busy),
        .bcd_valid  (bcd_valid),
        .bcd_value  (bcd_value),
        .anode      (anode),
        .segments   (segments),
        .dp         (dp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock or posedge reset) begin
        if (reset) tb_cnt <= 4'd0;
        else       tb_cnt <= tb_cnt + 4'd1;
    end

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b0111111;

    typedef struct packed {
        logic [7:0]  val;
        logic [11:0] bcd;
        logic [6:0]  s0;
        logic [6:0]  s1;
        logic [6:0]  s2;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scan a full refresh period and check anode/segments for every digit.
    task automatic chk_display(input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2);
        logic [6:0] exp_seg;
        logic [3:0] exp_an;
        logic [1:0] idx;
        for (int i = 0; i < 16; i++) begin
            idx = tb_cnt[3:2];
            case (idx)
                2'd0:    exp_seg = s0;
                2'd1:    exp_seg = s1;
                2'd2:    exp_seg = s2;
                default: exp_seg = BLANK;
            endcase
            exp_an = (exp_seg == BLANK) ? 4'b1111 : ~(4'b0001 << idx);
            chk("anode", anode, exp_an);
            chk("segments", segments, exp_seg);
            tick();
        end
    endtask

    // One-cycle pulse, then count busy cycles (bounded).
    task automatic convert(input logic [7:0] v, output int nbusy);
        gcd_ready  = 1'b1;
        gcd_result = v;
        tick();
        gcd_ready  = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            nbusy++;
            tick();
        end
    endtask

    int n;
    int rises;
    logic prev_busy;

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        gcd_ready  = 1'b0;
        gcd_result = 8'd0;

        //            val     bcd      ones        tens        hundreds
        vecs[0] = '{8'd255, 12'h255, 7'b0010010, 7'b0010010, 7'b0100100};
        vecs[1] = '{8'd0,   12'h000, 7'b1000000, BLANK,      BLANK};
        vecs[2] = '{8'd7,   12'h007, 7'b1111000, BLANK,      BLANK};
        vecs[3] = '{8'd40,  12'h040, 7'b1000000, 7'b0011001, BLANK};
        vecs[4] = '{8'd144, 12'h144, 7'b0011001, 7'b0011001, 7'b1111001};
        vecs[5] = '{8'd100, 12'h100, 7'b1000000, 7'b1000000, 7'b1111001};
        vecs[6] = '{8'd99,  12'h099, 7'b0010000, 7'b0010000, BLANK};
        vecs[7] = '{8'd208, 12'h208, 7'b0000000, 7'b1000000, 7'b0100100};

        // Reset state
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_valid", bcd_valid, 0);
        chk("rst_value", bcd_value, 12'h000);
        chk("dp", dp, 1);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) chk_display(DASH, DASH, DASH);

        // Table of conversions
        foreach (vecs[j]) begin
            convert(vecs[j].val, n);
            chk("busy_len", n, 8);
            chk("valid", bcd_valid, 1);
            chk("bcd", bcd_value, vecs[j].bcd);
            chk_display(vecs[j].s0, vecs[j].s1, vecs[j].s2);
        end

        // Rise during conversion is dropped
        gcd_ready  = 1'b1;
        gcd_result = 8'd12;
        tick();
        gcd_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) n++;
            if (i == 3) begin
                gcd_ready  = 1'b1;
                gcd_result = 8'd99;
            end
            if (i == 4) gcd_ready = 1'b0;
            tick();
        end
        chk("drop_busy_len", n, 8);
        chk("drop_bcd", bcd_value, 12'h012);
        convert(8'd99, n);
        chk("after_drop_len", n, 8);
        chk("after_drop_bcd", bcd_value, 12'h099);

        // Held-high level yields exactly one capture
        gcd_result = 8'd144;
        gcd_ready  = 1'b1;
        n = 0;
        rises = 0;
        prev_busy = 1'b0;
        for (int i = 0; i < 45; i++) begin
            if (i == 30) gcd_ready = 1'b0;
            tick();
            if (busy) n++;
            if (busy && !prev_busy) rises++;
            prev_busy = busy;
        end
        chk("held_rises", rises, 1);
        chk("held_busy_len", n, 8);
        chk("held_bcd", bcd_value, 12'h144);

        // Reset mid-conversion
        gcd_ready  = 1'b1;
        gcd_result = 8'd200;
        tick();
        gcd_ready = 1'b0;
        tick(); tick(); tick(); tick();
        chk("pre_rst_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", bcd_valid, 0);
        chk("mid_rst_value", bcd_value, 12'h000);
        chk("mid_rst_anode", anode, 4'b1110);
        chk("mid_rst_seg", segments, DASH);
        tick();
        reset = 1'b0;
        tick();
        convert(8'd6, n);
        chk("post_rst_len", n, 8);
        chk("post_rst_bcd", bcd_value, 12'h006);
        chk_display(7'b0000010, BLANK, BLANK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
